intt_out_drain: RTL and testbench
=================================

// Module: intt_out_drain
// PURPOSE
// - Consumer end of the INTT router output path: captures out/address_out beats emitted after the last
//   butterfly stage and streams the finished polynomial in natural coefficient order on valid/ready.
// - Router side has no backpressure, so the block is a ping-pong buffer: one bank fills while the other drains.
// PARAMETERS
// LOG_CORE_COUNT  5   log2 of butterfly core count C; must match the router
// LOG_N           12  log2 of polynomial length N
// COEFF_W         30  coefficient width; router words are 2*COEFF_W wide
// PORTS
// clk        in   1                  clock, all logic on posedge
// rst_n      in   1                  asynchronous active-low reset
// in_valid   in   1                  beat present on in_addr/in_data this cycle; no backpressure
// in_addr    in   9                  router address_out; beat index a = in_addr[LOG_N-LOG_CORE_COUNT-3:0]
// in_data    in   [2*COEFF_W-1:0] x [C][2]  router out[k][j]
// m_valid    out  1                  output word valid
// m_ready    in   1                  downstream accept
// m_data     out  4*COEFF_W          4 consecutive coefficients, lane0 in LSBs
// m_index    out  LOG_N              coefficient index of lane0
// m_last     out  1                  last word of a polynomial
// busy       out  1                  any bank not EMPTY
// dup_err    out  1                  sticky: beat index written twice in one fill
// ovf_err    out  1                  sticky: beat dropped, no EMPTY bank
// addr_err   out  1                  sticky: in_addr bits above beat-index field nonzero
// poly_cnt   out  16                 completed-polynomial counter (see CONFIGURATION)
// BEHAVIOUR
// - Geometry: B = N/(4C) beats per polynomial (32 at defaults); B*C output words per polynomial (1024).
// - Mapping: coefficient index of in_data[k][j] half h (h=0 low COEFF_W bits) = k*(N/C) + 4a + 2j + h.
// - Banks: bank0, bank1, each B x C x 4*COEFF_W, plus B-bit present bitmap. Per-bank FSM:
//   EMPTY -> FILLING on first accepted beat; FILLING -> FULL on the edge where the bitmap becomes all ones;
//   FULL -> DRAINING when that bank is selected for drain; DRAINING -> EMPTY on the m_last handshake.
// - fill_sel: selects the fill bank; toggles on FILLING->FULL. drain_sel: selects the drain bank; toggles on the m_last handshake.
// - Accept rule: a beat is written only when the fill bank is EMPTY or FILLING.
//   Otherwise it is dropped and ovf_err is set.
//   A bank emptying in the same cycle does not count as free: that beat is dropped.
// - Duplicate a within one fill: data is overwritten and dup_err is set; the bitmap is unchanged.
// - addr_err: set when an upper in_addr bit is 1. The beat is still written using the low bits.
// - Drain order: k outer, a inner. Word = {in_data[k][1], in_data[k][0]} of beat a; m_index = k*(N/C) + 4a.
// - Output is registered. If the last beat lands at edge E, m_valid is high from the cycle after E+1
//   (1-cycle read stage).
// - After that, one word per cycle while m_ready=1, with no bubbles, including back-to-back polynomials.
// - m_valid && !m_ready: m_data, m_index and m_last are held stable, and m_valid does not drop.
// - The next polynomial's first word follows the m_last handshake with no gap if the other bank is FULL.
// - Reset values: m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, all *_err=0, poly_cnt=0,
//   both banks EMPTY, bitmaps clear, fill_sel=drain_sel=0. Bank RAM contents are not cleared.
// - Reset mid-fill or mid-drain aborts. A partial polynomial is discarded and never emitted.
// CONFIGURATION
// - INTT_DRAIN_CNT_EN defined: poly_cnt increments on each m_last handshake and wraps 0xFFFF->0.
// - INTT_DRAIN_CNT_EN undefined: poly_cnt is tied to 0 and no counter logic is built.
// TESTING
// - Fill 32 beats a=0..31, k-unique data, m_ready=1 -> 1024 words in index order;
//   first m_valid 2 cycles after the last beat; m_last only at m_index=4092.
// - Random m_ready (50%) -> no word lost or duplicated, outputs stable while stalled,
//   scoreboard matches the mapping.
// - Three polynomials back-to-back with m_ready=1 -> 3072 contiguous words, no ovf_err,
//   poly_cnt=3 with INTT_DRAIN_CNT_EN (0 without).
// - m_ready=0 while filling two polynomials, then a 65th beat -> ovf_err=1, beat dropped,
//   first two polynomials intact.
// - Beat a=5 sent twice, then in_addr=9'h100 -> dup_err=1, second a=5 data emitted, addr_err=1
//   and data written at a=0.
// - rst_n low for 1 cycle after 10 beats -> all outputs at reset values; a fresh 32-beat fill
//   then drains normally.

Source files
------------

// File: rtl/intt_out_drain_if.sv
// intt_out_drain_if: router beat input and drained coefficient stream for intt_out_drain.
// Ports: in_valid/in_addr/in_data come from the router and have no backpressure.
//        m_valid/m_ready/m_data/m_index/m_last go to the consumer as a valid/ready stream.
interface intt_out_drain_if #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 12,
  parameter int COEFF_W        = 30
) ();
  localparam int C = 1 << LOG_CORE_COUNT;

  logic                             in_valid;
  logic [8:0]                       in_addr;
  logic [C-1:0][1:0][2*COEFF_W-1:0] in_data;
  logic                             m_valid;
  logic                             m_ready;
  logic [4*COEFF_W-1:0]             m_data;
  logic [LOG_N-1:0]                 m_index;
  logic                             m_last;

  // slave: the drain block itself
  modport slave (
    input  in_valid, in_addr, in_data, m_ready,
    output m_valid, m_data, m_index, m_last
  );

  // master: router plus downstream consumer
  modport master (
    output in_valid, in_addr, in_data, m_ready,
    input  m_valid, m_data, m_index, m_last
  );
endinterface

// File: rtl/intt_out_drain.sv
// Purpose: ping-pong buffer that captures INTT router output beats and streams the polynomial in index order.
// Latency: last beat captured at edge E -> first word valid after edge E+1 (registered read stage).
// Backpressure: none toward the router (beats into a busy bank are dropped, ovf_err); m_ready stalls the drain.
// Ports: clk, rst_n (async active-low); bus (intt_out_drain_if.slave) carries beats in and words out;
//        busy, dup_err, ovf_err, addr_err (sticky) and poly_cnt are status outputs.
// Option: define INTT_DRAIN_CNT_EN to build the completed-polynomial counter; otherwise poly_cnt is 0.
module intt_out_drain #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 12,
  parameter int COEFF_W        = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  intt_out_drain_if.slave    bus,
  output logic               busy,
  output logic               dup_err,
  output logic               ovf_err,
  output logic               addr_err,
  output logic [15:0]        poly_cnt
);
  localparam int C  = 1 << LOG_CORE_COUNT;
  localparam int AW = LOG_N - LOG_CORE_COUNT - 2;  // beat-index width
  localparam int B  = 1 << AW;                     // beats per polynomial
  localparam int CW = LOG_N - 2;                   // drain counter {k, a}
  localparam int WW = 4 * COEFF_W;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
  typedef logic [C-1:0][WW-1:0] row_t;  // one beat: word k = {in_data[k][1], in_data[k][0]}

  row_t          mem0 [B];
  row_t          mem1 [B];

  bank_st_t      st_q [2];
  bank_st_t      st_d [2];
  logic [B-1:0]  bm_q [2];
  logic [B-1:0]  bm_d [2];
  logic          fill_sel_q, fill_sel_d;
  logic          drain_sel_q, drain_sel_d;
  logic          dup_q, dup_d, ovf_q, ovf_d, aerr_q, aerr_d;
  logic [CW-1:0] cnt_q;
  logic          m_valid_q, m_last_q;
  logic [WW-1:0] m_data_q;
  logic [LOG_N-1:0] m_index_q;

  logic [AW-1:0] wr_a;
  logic          accept;
  logic [B-1:0]  bm_new;
  logic          hs, last_hs, src_bank, src_ok, load;
  logic [LOG_CORE_COUNT-1:0] rd_k;
  logic [AW-1:0] rd_a;
  logic [WW-1:0] rd_word;

  // Fill side: registered state only, so a bank emptying this cycle still refuses the beat.
  assign wr_a   = bus.in_addr[AW-1:0];
  assign accept = bus.in_valid && (st_q[fill_sel_q] == EMPTY || st_q[fill_sel_q] == FILLING);
  assign bm_new = bm_q[fill_sel_q] | (B'(1) << wr_a);

  // Drain side: on the m_last handshake the next word comes from the other bank, so
  // polynomials stream back-to-back. A DRAINING bank whose last word already sits in
  // the output register has nothing more to give.
  assign hs       = m_valid_q && bus.m_ready;
  assign last_hs  = hs && m_last_q;
  assign src_bank = last_hs ? ~drain_sel_q : drain_sel_q;
  assign src_ok   = (st_q[src_bank] == FULL) ||
                    (st_q[src_bank] == DRAINING && !(m_valid_q && m_last_q));
  assign load     = (!m_valid_q || bus.m_ready) && src_ok;

  assign rd_k    = cnt_q[CW-1 -: LOG_CORE_COUNT];
  assign rd_a    = cnt_q[AW-1:0];
  assign rd_word = src_bank ? mem1[rd_a][rd_k] : mem0[rd_a][rd_k];

  always_comb begin
    st_d        = st_q;
    bm_d        = bm_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    dup_d       = dup_q;
    ovf_d       = ovf_q;
    aerr_d      = aerr_q;
    if (accept) begin
      dup_d = dup_q | bm_q[fill_sel_q][wr_a];
      if (&bm_new) begin
        // bitmap is cleared here so the bank's next fill starts fresh
        st_d[fill_sel_q] = FULL;
        bm_d[fill_sel_q] = '0;
        fill_sel_d       = ~fill_sel_q;
      end else begin
        st_d[fill_sel_q] = FILLING;
        bm_d[fill_sel_q] = bm_new;
      end
    end
    if (bus.in_valid && !accept) ovf_d = 1'b1;
    if (bus.in_valid && |bus.in_addr[8:AW]) aerr_d = 1'b1;
    if (load && st_q[src_bank] == FULL) st_d[src_bank] = DRAINING;
    if (last_hs) begin
      st_d[drain_sel_q] = EMPTY;
      drain_sel_d       = ~drain_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      bm_q[0]     <= '0;
      bm_q[1]     <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      dup_q       <= 1'b0;
      ovf_q       <= 1'b0;
      aerr_q      <= 1'b0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_index_q   <= '0;
      m_last_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      bm_q        <= bm_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      dup_q       <= dup_d;
      ovf_q       <= ovf_d;
      aerr_q      <= aerr_d;
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= rd_word;
        m_index_q <= {cnt_q, 2'b00};  // k*(N/C) + 4a
        m_last_q  <= &cnt_q;
        cnt_q     <= cnt_q + 1'b1;    // wraps to 0 for the next polynomial
      end else if (hs) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  // Bank RAM: no reset, contents survive reset but are unreachable until refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (fill_sel_q) mem1[wr_a] <= bus.in_data;
      else            mem0[wr_a] <= bus.in_data;
    end
  end

`ifdef INTT_DRAIN_CNT_EN
  logic [15:0] poly_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       poly_cnt_q <= '0;
    else if (last_hs) poly_cnt_q <= poly_cnt_q + 16'd1;
  end
  assign poly_cnt = poly_cnt_q;
`else
  assign poly_cnt = '0;
`endif

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_index = m_index_q;
  assign bus.m_last  = m_last_q;
  assign busy        = (st_q[0] != EMPTY) || (st_q[1] != EMPTY);
  assign dup_err     = dup_q;
  assign ovf_err     = ovf_q;
  assign addr_err    = aerr_q;
endmodule

// File: tb/tb_intt_out_drain.sv
// Bench for intt_out_drain: directed fills, drains collected by a negedge monitor,
// expected words rebuilt from the coefficient-index mapping.
module tb_intt_out_drain;
  localparam int LCC = 5, LN = 12, CWID = 30;
  localparam int C = 32, B = 32, WPP = 1024;
`ifdef INTT_DRAIN_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        busy, dup_err, ovf_err, addr_err;
  logic [15:0] poly_cnt;

  intt_out_drain_if #(.LOG_CORE_COUNT(LCC), .LOG_N(LN), .COEFF_W(CWID)) bus ();

  intt_out_drain #(.LOG_CORE_COUNT(LCC), .LOG_N(LN), .COEFF_W(CWID)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .dup_err(dup_err),
    .ovf_err(ovf_err), .addr_err(addr_err), .poly_cnt(poly_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // coefficient value encodes the polynomial seed and its own index
  function automatic logic [CWID-1:0] coef(input int s, input int idx);
    logic [5:0]  sv;
    logic [11:0] iv;
    sv = 6'(s);
    iv = 12'(idx);
    return {sv, iv, ~iv};
  endfunction

  function automatic logic [C-1:0][1:0][2*CWID-1:0] mk_beat(input int s, input int a);
    logic [C-1:0][1:0][2*CWID-1:0] d;
    for (int k = 0; k < C; k++)
      for (int j = 0; j < 2; j++)
        d[k][j] = {coef(s, k*128 + 4*a + 2*j + 1), coef(s, k*128 + 4*a + 2*j)};
    return d;
  endfunction

  function automatic logic [4*CWID-1:0] exp_word(input int s, input int i);
    return {coef(s, i+3), coef(s, i+2), coef(s, i+1), coef(s, i)};
  endfunction

  // ---------------- monitor ----------------
  logic [4*CWID-1:0] obs_dat[$];
  int                obs_idx[$];
  bit                obs_last[$];
  int                obs_cyc[$];
  int                cyc = 0;
  bit                prev_stall = 0;
  logic [4*CWID-1:0] pd;
  logic [LN-1:0]     pi;
  logic              pl;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", bus.m_valid, 1);
        chk("stall_dat", bus.m_data, pd);
        chk("stall_idx", bus.m_index, pi);
        chk("stall_last", bus.m_last, pl);
      end
      if (bus.m_valid && bus.m_ready) begin
        obs_dat.push_back(bus.m_data);
        obs_idx.push_back(int'(bus.m_index));
        obs_last.push_back(bus.m_last);
        obs_cyc.push_back(cyc);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      pd = bus.m_data;
      pi = bus.m_index;
      pl = bus.m_last;
    end
  end

  // ---------------- m_ready driver ----------------
  int rdy_mode = 1;  // 0: stalled, 1: always ready, 2: random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers ----------------
  int exp_sa[B];

  task automatic set_sa(input int s);
    for (int a = 0; a < B; a++) exp_sa[a] = s;
  endtask

  task automatic beat(input logic [8:0] addr, input int s, input int a);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_data  = mk_beat(s, a);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic fill(input int s);
    for (int a = 0; a < B; a++) beat(9'(a), s, a);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_mvalid"}, bus.m_valid, 0);
    chk({tag, "_mdata"}, bus.m_data, 0);
    chk({tag, "_mindex"}, bus.m_index, 0);
    chk({tag, "_mlast"}, bus.m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dup"}, dup_err, 0);
    chk({tag, "_ovf"}, ovf_err, 0);
    chk({tag, "_aerr"}, addr_err, 0);
    chk({tag, "_pcnt"}, poly_cnt, 0);
  endtask

  // one cycle of reset; outputs checked while it is asserted
  task automatic reset_chk(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_idle(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_dat.delete(); obs_idx.delete(); obs_last.delete(); obs_cyc.delete();
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int t = 0;
    while (obs_dat.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_wordcount"}, obs_dat.size() >= n, 1);
  endtask

  task automatic verify_poly(input string tag);
    for (int w = 0; w < WPP; w++) begin
      int k, a, idx;
      k = w / B;
      a = w % B;
      idx = k*128 + 4*a;
      if (obs_dat.size() == 0) begin
        chk({tag, "_missing_at"}, w, WPP);
        return;
      end
      chk({tag, "_idx"}, obs_idx.pop_front(), idx);
      chk({tag, "_dat"}, obs_dat.pop_front(), exp_word(exp_sa[a], idx));
      chk({tag, "_last"}, obs_last.pop_front(), (w == WPP-1));
      obs_cyc.delete(0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int span;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.m_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single polynomial, latency and order
    rdy_mode = 1;
    fill(1);
    idle(1);
    @(negedge clk);
    chk("lat_early_vld", bus.m_valid, 0);
    @(negedge clk);
    chk("lat_first_vld", bus.m_valid, 1);
    chk("lat_first_idx", bus.m_index, 0);
    chk("drain_busy", busy, 1);
    wait_words("p1", WPP, 1200);
    set_sa(1);
    verify_poly("p1");
    idle(5);
    chk("p1_busy_after", busy, 0);
    chk("p1_pcnt", poly_cnt, CNT_EN);

    // random backpressure
    rdy_mode = 2;
    fill(2);
    idle(1);
    wait_words("rnd", WPP, 6000);
    set_sa(2);
    verify_poly("rnd");
    rdy_mode = 1;
    idle(5);

    // three polynomials, contiguous output
    reset_chk("rst4");
    fill(3);
    fill(4);
    idle(1040);
    fill(5);
    idle(1);
    wait_words("b2b", 3*WPP, 3500);
    span = (obs_cyc.size() >= 3*WPP) ? obs_cyc[3*WPP-1] - obs_cyc[0] : -1;
    chk("b2b_span", span, 3*WPP-1);
    set_sa(3); verify_poly("b2b_a");
    set_sa(4); verify_poly("b2b_b");
    set_sa(5); verify_poly("b2b_c");
    idle(3);
    chk("b2b_ovf", ovf_err, 0);
    chk("b2b_pcnt", poly_cnt, 3*CNT_EN);

    // overflow: both banks held, 65th beat dropped
    reset_chk("rst5");
    rdy_mode = 0;
    fill(6);
    fill(7);
    beat(9'd0, 8, 0);
    idle(1);
    @(negedge clk);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_nodup", dup_err, 0);
    rdy_mode = 1;
    wait_words("ovf", 2*WPP, 2500);
    set_sa(6); verify_poly("ovf_a");
    set_sa(7); verify_poly("ovf_b");

    // duplicate beat and out-of-range address bits
    reset_chk("rst6");
    beat(9'd5, 10, 5);
    beat(9'd5, 11, 5);
    beat(9'h100, 12, 0);
    for (int a = 1; a < B; a++)
      if (a != 5) beat(9'(a), 10, a);
    idle(1);
    @(negedge clk);
    chk("dup_set", dup_err, 1);
    chk("aerr_set", addr_err, 1);
    chk("dup_noovf", ovf_err, 0);
    wait_words("dup", WPP, 1200);
    set_sa(10);
    exp_sa[5] = 11;
    exp_sa[0] = 12;
    verify_poly("dup");

    // reset mid-fill discards the partial polynomial
    idle(2);
    for (int a = 0; a < 10; a++) beat(9'(a), 13, a);
    reset_chk("rst7");
    @(negedge clk);
    check_idle("post7");
    fill(14);
    idle(1);
    wait_words("fresh", WPP, 1200);
    set_sa(14);
    verify_poly("fresh");
    idle(50);
    chk("fresh_no_stale", obs_dat.size(), 0);
    chk("fresh_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
